data_mem_unit: RTL

- Multi-cycle data-memory responder. Serves the load/store requests that the main decoder raises via mem_read / mem_write.
- Holds a doubleword-organised RAM. Performs byte/half/word/double accesses with sign or zero extension on loads.
- Signals completion with a one-cycle done pulse and holds the datapath with stall until then.
- Sits between the ALU address output and the MemtoReg writeback mux.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/data_mem_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM state encoding and the byte-enable mask helper.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  // size: 0=byte, 1=half, 2=word, 3=double; offset is the byte lane of the access.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store-data shift and byte enables, load-lane
// extract with sign/zero extension, and the natural-alignment check.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      offset_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] ram_rdata_i,
  output logic [XLEN-1:0] wdata_lanes_o,
  output logic [7:0]      byte_en_o,
  output logic [XLEN-1:0] rdata_ext_o,
  output logic            misaligned_o
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;

  assign shamt         = {offset_i, 3'b000};
  assign wdata_lanes_o = wdata_i << shamt;
  assign byte_en_o     = byte_mask(funct3_i[1:0], offset_i);
  assign lane          = ram_rdata_i >> shamt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'd1:    misaligned_o = offset_i[0];
      2'd2:    misaligned_o = |offset_i[1:0];
      2'd3:    misaligned_o = |offset_i;
      default: misaligned_o = 1'b0;
    endcase
  end

  always_comb begin
    rdata_ext_o = '0;
    case (funct3_i)
      F3_LB:   rdata_ext_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_LH:   rdata_ext_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_LW:   rdata_ext_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3_LD:   rdata_ext_o = lane;
      F3_LBU:  rdata_ext_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_LHU:  rdata_ext_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_LWU:  rdata_ext_o = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: rdata_ext_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle load/store responder over a doubleword RAM. Accepts a request in
// IDLE, completes it LATENCY cycles later with a one-cycle done pulse.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            stall,
  output logic            access_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW+2:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            rd_q, wr_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [XLEN-1:0] mem [DEPTH];

  logic            req, idle, enter_resp;
  logic [AW+2:0]   cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic [2:0]      cur_funct3;
  logic            cur_rd, cur_wr;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] ram_word, wdata_lanes, rdata_ext;
  logic [7:0]      byte_en;
  logic            misaligned, acc_err, load_ok, store_ok, ram_we;
  logic            unused_addr_hi;

  assign req  = mem_read | mem_write;
  assign idle = (state_q == IDLE);

  // With LATENCY=1 the commit edge is the acceptance edge, so the live request
  // is used in IDLE and the latched copy afterwards.
  assign cur_addr   = idle ? addr[AW+2:0] : addr_q;
  assign cur_wdata  = idle ? wdata        : wdata_q;
  assign cur_funct3 = idle ? funct3       : funct3_q;
  assign cur_rd     = idle ? mem_read     : rd_q;
  assign cur_wr     = idle ? mem_write    : wr_q;

  assign word_idx       = cur_addr[AW+2:3];
  assign ram_word       = mem[word_idx];
  assign unused_addr_hi = ^addr[XLEN-1:AW+3];

  mem_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .funct3_i      (cur_funct3),
    .offset_i      (cur_addr[2:0]),
    .wdata_i       (cur_wdata),
    .ram_rdata_i   (ram_word),
    .wdata_lanes_o (wdata_lanes),
    .byte_en_o     (byte_en),
    .rdata_ext_o   (rdata_ext),
    .misaligned_o  (misaligned)
  );

  assign acc_err  = (cur_rd & cur_wr) | (cur_funct3 == F3_ILL) |
                    (cur_wr & cur_funct3[2]) | misaligned;
  assign load_ok  = cur_rd & ~cur_wr & ~acc_err;
  assign store_ok = cur_wr & ~cur_rd & ~acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only entries into RESP produce state_d==RESP; rst_n gates a write that
  // would coincide with reset.
  assign enter_resp = (state_d == RESP);
  assign ram_we     = enter_resp & store_ok & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        addr_q   <= addr[AW+2:0];
        wdata_q  <= wdata;
        funct3_q <= funct3;
        rd_q     <= mem_read;
        wr_q     <= mem_write;
      end
      rdata_q <= (enter_resp && load_ok) ? rdata_ext : '0;
      err_q   <= enter_resp & acc_err;
    end
  end

  // NOTE: the RAM array has no reset; clearing it would force a flop-based array.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign rdata      = rdata_q;
  assign done       = (state_q == RESP);
  assign access_err = err_q;
  assign stall      = (req && idle) || (state_q == BUSY);

endmodule
